// File: rtl/decoder_38_u24_pkg.sv
// Shared constants and helpers for the registered 3-to-8 decoder.
package decoder_38_u24_pkg;

  localparam int unsigned IN_W  = 3;
  localparam int unsigned OUT_W = 8;

  localparam logic [OUT_W-1:0] Y_RESET = 8'h00;

  // One-hot word with bit `code` set; used wherever a reference decode is needed.
  function automatic logic [OUT_W-1:0] onehot8(input logic [IN_W-1:0] code);
    logic [OUT_W-1:0] w;
    w = '0;
    w[code] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/decoder_38_u24_decoder24.sv
// Combinational 2-to-4 decoder with enable; the building block of the 3-to-8 composition.
module decoder24 (
  input  logic [1:0] a,
  input  logic       e,
  output logic [3:0] q
);

  // Shift a single set bit to position a, or output zeros when disabled.
  always_comb begin
    q = 4'h0;
    if (e) q = 4'b0001 << a;
  end

endmodule

// File: rtl/decoder_38_u24.sv
// Registered 3-to-8 one-hot decoder built from two 2-to-4 decoders.
// i[2] selects which half is enabled; en gates both halves.
module decoder_38_u24
  import decoder_38_u24_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [IN_W-1:0]   i,
  output logic [OUT_W-1:0]  y
);

  logic             en_lo;
  logic             en_hi;
  logic [3:0]       d_lo;
  logic [3:0]       d_hi;
  logic [OUT_W-1:0] y_d;
  logic [OUT_W-1:0] y_q;

  assign en_lo = en & ~i[2];
  assign en_hi = en &  i[2];

  decoder24 u_dec_lo (
    .a (i[1:0]),
    .e (en_lo),
    .q (d_lo)
  );

  decoder24 u_dec_hi (
    .a (i[1:0]),
    .e (en_hi),
    .q (d_hi)
  );

  assign y_d = {d_hi, d_lo};

  // Output register; reset clears it immediately, discarding any in-flight decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_q <= Y_RESET;
    else        y_q <= y_d;
  end

  assign y = y_q;

endmodule

// File: tb/tb_decoder_38_u24.sv
// Self-checking bench for decoder_38_u24: directed vector table, hand-written
// reset sequences and a randomized run against an arithmetic reference.
module tb_decoder_38_u24;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] i;
  logic [7:0] y;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      name;
    logic       en;
    logic [2:0] i;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  decoder_38_u24 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .i     (i),
    .y     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs, let one rising edge capture them, then sample just after the edge.
  task automatic apply(input logic en_v, input logic [2:0] i_v);
    en = en_v;
    i  = i_v;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ref_decode(input logic en_v, input logic [2:0] i_v);
    int unsigned v;
    v = en_v ? (1 << i_v) : 0;
    return v[7:0];
  endfunction

  initial begin
    logic       r_en;
    logic [2:0] r_i;
    logic [7:0] exp_y;

    vecs.push_back('{"sweep_000", 1'b1, 3'b000, 8'b00000001});
    vecs.push_back('{"sweep_001", 1'b1, 3'b001, 8'b00000010});
    vecs.push_back('{"sweep_010", 1'b1, 3'b010, 8'b00000100});
    vecs.push_back('{"sweep_011", 1'b1, 3'b011, 8'b00001000});
    vecs.push_back('{"sweep_100", 1'b1, 3'b100, 8'b00010000});
    vecs.push_back('{"sweep_101", 1'b1, 3'b101, 8'b00100000});
    vecs.push_back('{"sweep_110", 1'b1, 3'b110, 8'b01000000});
    vecs.push_back('{"sweep_111", 1'b1, 3'b111, 8'b10000000});
    vecs.push_back('{"en_off_011", 1'b0, 3'b011, 8'b00000000});
    vecs.push_back('{"en_on_011",  1'b1, 3'b011, 8'b00001000});
    vecs.push_back('{"bnd_000",    1'b1, 3'b000, 8'b00000001});
    vecs.push_back('{"bnd_111",    1'b1, 3'b111, 8'b10000000});
    vecs.push_back('{"en_off_111", 1'b0, 3'b111, 8'b00000000});
    vecs.push_back('{"en_on_100",  1'b1, 3'b100, 8'b00010000});

    // Reset asserted with a live code on the inputs.
    rst_n = 1'b1;
    en    = 1'b1;
    i     = 3'b101;
    #2 rst_n = 1'b0;
    #1 check("reset_immediate", y, 8'h00);
    repeat (2) @(posedge clk);
    #1 check("reset_held", y, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("reset_before_release", y, 8'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("reset_release_101", y, 8'b00100000);

    // Directed vector table.
    foreach (vecs[k]) begin
      apply(vecs[k].en, vecs[k].i);
      check(vecs[k].name, y, vecs[k].exp);
    end

    // Mid-stream reset: 110 captured, 111 in flight when reset pulses.
    apply(1'b1, 3'b110);
    check("mid_110", y, 8'b01000000);
    i = 3'b111;
    #2 rst_n = 1'b0;
    #1 check("mid_reset_async", y, 8'h00);
    #1 rst_n = 1'b1;
    #1 check("mid_reset_no_edge", y, 8'h00);
    @(posedge clk);
    #1 check("mid_after_release_111", y, 8'b10000000);

    // Randomized run against the arithmetic reference.
    for (int c = 0; c < 1000; c++) begin
      r_en  = ($urandom_range(0, 7) != 0);
      r_i   = 3'($urandom_range(0, 7));
      exp_y = ref_decode(r_en, r_i);
      apply(r_en, r_i);
      check("rand_decode", y, exp_y);
      check("rand_popcount_le1", 8'($countones(y) <= 1), 8'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
